fetch_ctrl: RTL and testbench

- Fetch-side sequencer that drives the IF stage's Branch, Target and Halt inputs.
- Consumes the instruction currently addressed by PC (asynchronous instruction ROM output) plus the datapath Match flag.
- Implements three things: loop repeat (PC-1), search skip (PC+2) and halt/restart.
- Mealy block: outputs are combinational from the registered state plus Instr, so IF sees them before the same posedge that updates PC.

---
 rtl/fetch_ctrl_pkg.sv | 19 +
 rtl/fetch_loop_cnt.sv | 35 +++
 rtl/fetch_ctrl.sv | 135 +++++++++++++
 tb/tb_fetch_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the fetch-side sequencer: opcodes, IF branch codes and FSM states.
package fetch_ctrl_pkg;

   localparam logic [2:0] OP_HLT  = 3'b100;
   localparam logic [2:0] OP_LDC  = 3'b101;
   localparam logic [2:0] OP_RPT  = 3'b110;
   localparam logic [2:0] OP_SRCH = 3'b111;

   localparam logic [1:0] BR_SEQ  = 2'd0;
   localparam logic [1:0] BR_BACK = 2'd1;
   localparam logic [1:0] BR_SKIP = 2'd2;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_WAIT   = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

endpackage

// File: rtl/fetch_loop_cnt.sv
// Loop repeat counter: loadable, decrements toward zero and never wraps.
module fetch_loop_cnt #(
   parameter int CW = 6
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          load_i,
   input  logic          dec_i,
   input  logic [CW-1:0] load_val_i,
   output logic [CW-1:0] cnt_o,
   output logic          zero_o
);

   logic [CW-1:0] cnt_q, cnt_d;

   assign zero_o = (cnt_q == '0);
   assign cnt_o  = cnt_q;

   // A load takes priority so a nested LDC always overwrites the count.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && !zero_o)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Mealy fetch sequencer driving IF Branch/Target/Halt: loop repeat, search skip, halt/restart.
// Optional RUN-cycle counter on CycleCnt is built only when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int IW       = 9,
   parameter int CW       = 6,
   parameter int SRCH_LAT = 3
) (
   input  logic          CLK,
   input  logic          Init_n,
   input  logic [IW-1:0] Instr,
   input  logic          Match,
   input  logic          Start,
   output logic [1:0]    Branch,
   output logic [7:0]    Target,
   output logic          Halt,
   output logic [CW-1:0] LoopCnt,
   output logic [15:0]   CycleCnt
);

   localparam int WW = (SRCH_LAT > 2) ? $clog2(SRCH_LAT) : 1;

   state_e        state_q, state_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [2:0]    opcode;
   logic [1:0]    br_c;
   logic          halt_c, ld_c, dec_c, cnt_zero;

   assign opcode = Instr[IW-1:IW-3];

   fetch_loop_cnt #(.CW(CW)) u_loop_cnt (
      .clk_i      (CLK),
      .rst_ni     (Init_n),
      .load_i     (ld_c),
      .dec_i      (dec_c),
      .load_val_i (Instr[CW-1:0]),
      .cnt_o      (LoopCnt),
      .zero_o     (cnt_zero)
   );

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      br_c    = BR_SEQ;
      halt_c  = 1'b0;
      ld_c    = 1'b0;
      dec_c   = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            unique case (opcode)
               OP_LDC: ld_c = 1'b1;
               OP_RPT: begin
                  if (!cnt_zero) begin
                     br_c  = BR_BACK;
                     dec_c = 1'b1;
                  end
               end
               OP_SRCH: begin
                  if (SRCH_LAT == 1) begin
                     br_c = Match ? BR_SKIP : BR_SEQ;
                  end else begin
                     halt_c  = 1'b1;
                     wait_d  = WW'(SRCH_LAT - 2);
                     state_d = ST_WAIT;
                  end
               end
               OP_HLT: begin
                  halt_c  = 1'b1;
                  state_d = ST_HALTED;
               end
               default: ;
            endcase
         end
         // Instr is held by Halt, so Match is only trusted in the last wait cycle.
         ST_WAIT: begin
            if (wait_q == '0) begin
               br_c    = Match ? BR_SKIP : BR_SEQ;
               state_d = ST_RUN;
            end else begin
               halt_c = 1'b1;
               wait_d = wait_q - 1'b1;
            end
         end
         ST_HALTED: begin
            if (Start)
               state_d = ST_RUN;
            else
               halt_c = 1'b1;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge CLK or negedge Init_n) begin
      if (!Init_n) begin
         state_q <= ST_RUN;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // Instr-dependent outputs must be masked while reset is held.
   assign Branch = Init_n ? br_c : BR_SEQ;
   assign Halt   = !Init_n || halt_c;
   assign Target = 8'h00;

`ifdef FETCH_CTRL_PERF_EN
   logic [15:0] cyc_q, cyc_d;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_comb begin
      cyc_d = cyc_q;
      if (state_q == ST_RUN)
         cyc_d = sat_inc16(cyc_q);
   end

   always_ff @(posedge CLK or negedge Init_n) begin
      if (!Init_n)
         cyc_q <= '0;
      else
         cyc_q <= cyc_d;
   end

   assign CycleCnt = cyc_q;
`else
   assign CycleCnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: vector table plus hand-written reset and perf-counter sequences.
module tb_fetch_ctrl;

   logic       CLK = 1'b0;
   logic       Init_n;
   logic [8:0] Instr;
   logic       Match;
   logic       Start;
   logic [1:0] Branch;
   logic [7:0] Target;
   logic       Halt;
   logic [5:0] LoopCnt;
   logic [15:0] CycleCnt;

   int checks   = 0;
   int failures = 0;

   fetch_ctrl #(.IW(9), .CW(6), .SRCH_LAT(3)) dut (
      .CLK      (CLK),
      .Init_n   (Init_n),
      .Instr    (Instr),
      .Match    (Match),
      .Start    (Start),
      .Branch   (Branch),
      .Target   (Target),
      .Halt     (Halt),
      .LoopCnt  (LoopCnt),
      .CycleCnt (CycleCnt)
   );

   always #5 CLK = ~CLK;

   localparam logic [8:0] NOP  = 9'h000;
   localparam logic [8:0] HLT  = 9'h100;
   localparam logic [8:0] RPT  = 9'h180;
   localparam logic [8:0] SRCH = 9'h1C0;

   typedef struct {
      logic [8:0] instr;
      logic       match;
      logic       start;
      logic [1:0] br;
      logic       halt;
      logic [5:0] loop;
   } vec_t;

   vec_t vecs[32];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called just after a posedge: drive, check Mealy outputs mid-cycle, then registered LoopCnt.
   task automatic apply(input string tag, input vec_t v);
      Instr = v.instr;
      Match = v.match;
      Start = v.start;
      @(negedge CLK);
      chk({tag, ".Branch"}, 32'(Branch), 32'(v.br));
      chk({tag, ".Halt"}, 32'(Halt), 32'(v.halt));
      chk({tag, ".Target"}, 32'(Target), 32'h0);
      @(posedge CLK);
      #1;
      chk({tag, ".LoopCnt"}, 32'(LoopCnt), 32'(v.loop));
   endtask

   function automatic vec_t mk(input logic [8:0] i, input logic m, input logic s,
                               input logic [1:0] b, input logic h, input logic [5:0] l);
      vec_t v;
      v.instr = i; v.match = m; v.start = s; v.br = b; v.halt = h; v.loop = l;
      return v;
   endfunction

   task automatic do_reset();
      Init_n = 1'b0;
      #2;
      Init_n = 1'b1;
   endtask

   initial begin
      vecs[0]  = mk(NOP,    0, 0, 0, 0, 0);
      vecs[1]  = mk(NOP,    0, 0, 0, 0, 0);
      vecs[2]  = mk(NOP,    0, 0, 0, 0, 0);
      vecs[3]  = mk(9'h142, 0, 0, 0, 0, 2);
      vecs[4]  = mk(RPT,    0, 0, 1, 0, 1);
      vecs[5]  = mk(RPT,    0, 0, 1, 0, 0);
      vecs[6]  = mk(RPT,    0, 0, 0, 0, 0);
      vecs[7]  = mk(SRCH,   0, 0, 0, 1, 0);
      vecs[8]  = mk(SRCH,   0, 0, 0, 1, 0);
      vecs[9]  = mk(SRCH,   1, 0, 2, 0, 0);
      vecs[10] = mk(SRCH,   0, 0, 0, 1, 0);
      vecs[11] = mk(SRCH,   0, 0, 0, 1, 0);
      vecs[12] = mk(SRCH,   0, 0, 0, 0, 0);
      vecs[13] = mk(SRCH,   1, 0, 0, 1, 0);
      vecs[14] = mk(SRCH,   0, 0, 0, 1, 0);
      vecs[15] = mk(SRCH,   0, 0, 0, 0, 0);
      vecs[16] = mk(9'h140, 0, 0, 0, 0, 0);
      vecs[17] = mk(RPT,    0, 0, 0, 0, 0);
      vecs[18] = mk(9'h143, 0, 0, 0, 0, 3);
      vecs[19] = mk(RPT,    0, 0, 1, 0, 2);
      vecs[20] = mk(9'h145, 0, 0, 0, 0, 5);
      vecs[21] = mk(RPT,    0, 0, 1, 0, 4);
      vecs[22] = mk(NOP,    0, 1, 0, 0, 4);
      vecs[23] = mk(HLT,    0, 0, 0, 1, 4);
      vecs[24] = mk(HLT,    0, 0, 0, 1, 4);
      vecs[25] = mk(HLT,    0, 0, 0, 1, 4);
      vecs[26] = mk(HLT,    0, 0, 0, 1, 4);
      vecs[27] = mk(HLT,    0, 1, 0, 0, 4);
      vecs[28] = mk(NOP,    0, 0, 0, 0, 4);
      vecs[29] = mk(SRCH,   0, 0, 0, 1, 4);
      vecs[30] = mk(SRCH,   0, 1, 0, 1, 4);
      vecs[31] = mk(SRCH,   1, 0, 2, 0, 4);

      // Reset held with an instruction that would otherwise skip.
      Init_n = 1'b0;
      Instr  = SRCH;
      Match  = 1'b1;
      Start  = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst.Branch", 32'(Branch), 32'h0);
      chk("rst.Halt", 32'(Halt), 32'h1);
      chk("rst.LoopCnt", 32'(LoopCnt), 32'h0);
      chk("rst.CycleCnt", 32'(CycleCnt), 32'h0);
      chk("rst.Target", 32'(Target), 32'h0);
      Init_n = 1'b1;

      // 9 NOPs plus HLT are 10 RUN cycles, then 3 HALTED cycles.
      for (int i = 0; i < 9; i++) apply("perf.nop", mk(NOP, 0, 0, 0, 0, 0));
      apply("perf.hlt", mk(HLT, 0, 0, 0, 1, 0));
      for (int i = 0; i < 3; i++) apply("perf.halted", mk(HLT, 0, 0, 0, 1, 0));
`ifdef FETCH_CTRL_PERF_EN
      chk("perf.CycleCnt", 32'(CycleCnt), 32'd10);
`else
      chk("perf.CycleCnt", 32'(CycleCnt), 32'd0);
`endif
      do_reset();
      chk("perf.CycleCnt_clr", 32'(CycleCnt), 32'd0);

      for (int i = 0; i < 32; i++) apply($sformatf("vec%0d", i), vecs[i]);

      // Asynchronous reset mid-cycle with a loaded counter and no clock edge.
      apply("async.ldc", mk(9'h147, 0, 0, 0, 0, 7));
      Instr = NOP;
      #2;
      Init_n = 1'b0;
      #1;
      chk("async.Halt", 32'(Halt), 32'h1);
      chk("async.LoopCnt", 32'(LoopCnt), 32'h0);
      @(posedge CLK);
      #1;
      Init_n = 1'b1;
      apply("async.after", mk(NOP, 0, 0, 0, 0, 0));

      // Reset while in WAIT must land back in RUN.
      apply("wait.enter", mk(SRCH, 0, 0, 0, 1, 0));
      Init_n = 1'b0;
      #1;
      chk("wait.rst.Halt", 32'(Halt), 32'h1);
      chk("wait.rst.Branch", 32'(Branch), 32'h0);
      @(posedge CLK);
      #1;
      Init_n = 1'b1;
      apply("wait.after", mk(NOP, 0, 0, 0, 0, 0));

      // Reset while HALTED must also return to RUN.
      apply("halt.enter", mk(HLT, 0, 0, 0, 1, 0));
      do_reset();
      apply("halt.after", mk(NOP, 0, 0, 0, 0, 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
